// File: rtl/booth_ctrl.sv
// booth_ctrl: sequencing controller and operand/product handshake stage for an
// N-bit radix-2 Booth multiplier datapath (datapath registers live downstream).
module booth_ctrl #(
    parameter int N = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    // Handshakes: a transfer happens on the rising edge where valid and ready are
    // both 1; valid and its payload stay stable until that edge, ready may change freely.
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in_m,
    input  logic [N-1:0]     in_q,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*N-1:0]   product,
    output logic [N-1:0]     data_M,
    output logic [N-1:0]     data_Q,
    output logic             ldA,
    output logic             clrA,
    output logic             sftA,
    output logic             ldQ,
    output logic             clrQ,
    output logic             sftQ,
    output logic             ldM,
    output logic             clrff,
    output logic             add_sub,
    output logic             ldC,
    output logic             dec,
    output logic             enf,
    input  logic             q0,
    input  logic             qm1,
    input  logic             eqz,
    input  logic [2*N-1:0]   data_out,
    output logic [2:0]       o_dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_SETTLE = 3'd2,
        S_EVAL   = 3'd3,
        S_SHIFT  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t           r_state;
    state_t           w_next;
    logic             r_in_ready;
    logic             r_out_valid;
    logic             r_load;
    logic             r_shift;
    logic [N-1:0]     r_op_m;
    logic [N-1:0]     r_op_q;
    logic [2*N-1:0]   r_product;
    logic             w_in_fire;
    logic             w_eval;

    assign w_in_fire = in_valid & r_in_ready;
    assign w_eval    = (r_state == S_EVAL);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (w_in_fire) w_next = S_LOAD;
            S_LOAD:   w_next = S_SETTLE;
            S_SETTLE: w_next = eqz ? S_DONE : S_EVAL;
            S_EVAL:   w_next = S_SHIFT;
            S_SHIFT:  w_next = S_SETTLE;
            S_DONE:   if (out_ready) w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // Strobes are decoded from the next state so they are registered yet line up
    // with the state they belong to.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_load      <= 1'b0;
            r_shift     <= 1'b0;
            r_op_m      <= '0;
            r_op_q      <= '0;
            r_product   <= '0;
        end else begin
            r_state     <= w_next;
            r_in_ready  <= (w_next == S_IDLE);
            r_out_valid <= (w_next == S_DONE);
            r_load      <= (w_next == S_LOAD);
            r_shift     <= (w_next == S_SHIFT);
            if (w_in_fire) begin
                r_op_m <= in_m;
                r_op_q <= in_q;
            end
            if ((r_state == S_SETTLE) && eqz) begin
                r_product <= data_out;
            end
        end
    end

    assign in_ready    = r_in_ready;
    assign out_valid   = r_out_valid;
    assign product     = r_product;
    assign data_M      = r_op_m;
    assign data_Q      = r_op_q;
    assign o_dbg_state = r_state;

    assign ldM   = r_load;
    assign ldQ   = r_load;
    assign clrA  = r_load;
    assign clrff = r_load;
    assign ldC   = r_load;
    assign sftA  = r_shift;
    assign sftQ  = r_shift;
    assign enf   = r_shift;
    assign dec   = r_shift;
    assign clrQ  = 1'b0;

    // q0/qm1 only become valid during EVAL itself, so the add/subtract strobes
    // are decoded in the same cycle rather than registered ahead.
    assign ldA     = w_eval & (q0 ^ qm1);
    assign add_sub = w_eval & ~q0 & qm1;

endmodule

// File: tb/tb_booth_ctrl.sv
// tb_booth_ctrl: booth_ctrl closed around a behavioural Booth datapath, with an
// arithmetic reference model feeding an expected-result scoreboard.
module tb_booth_ctrl;

  localparam int N = 4;
  localparam int W = 2 * N;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_m;
  logic [N-1:0] in_q;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] product;
  logic [N-1:0] data_m;
  logic [N-1:0] data_q;
  logic         lda, clra, sfta, ldq, clrq, sftq, ldm, clrff, add_sub, ldc, dec, enf;
  logic         q0, qm1, eqz;
  logic [W-1:0] data_out;
  logic [2:0]   dbg_state;

  booth_ctrl #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_m(in_m), .in_q(in_q),
    .out_valid(out_valid), .out_ready(out_ready), .product(product),
    .data_M(data_m), .data_Q(data_q),
    .ldA(lda), .clrA(clra), .sftA(sfta), .ldQ(ldq), .clrQ(clrq), .sftQ(sftq),
    .ldM(ldm), .clrff(clrff), .add_sub(add_sub), .ldC(ldc), .dec(dec), .enf(enf),
    .q0(q0), .qm1(qm1), .eqz(eqz), .data_out(data_out),
    .o_dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- behavioural datapath ----------------
  // A carries one guard bit so that (-2^(N-1)) x (-2^(N-1)) stays exact.
  logic [N:0]   dp_a = '0;
  logic [N-1:0] dp_q = '0;
  logic [N-1:0] dp_m = '0;
  logic         dp_qm1 = 1'b0;
  logic [2:0]   dp_cnt = '0;
  logic         dp_q0_d = 1'b0;
  logic         dp_qm1_d = 1'b0;

  always @(posedge clk) begin
    if (ldm) dp_m <= data_m;
    if (clra)      dp_a <= '0;
    else if (lda)  dp_a <= add_sub ? dp_a + {dp_m[N-1], dp_m} : dp_a - {dp_m[N-1], dp_m};
    else if (sfta) dp_a <= {dp_a[N], dp_a[N:1]};
    if (ldq)       dp_q <= data_q;
    else if (sftq) dp_q <= {dp_a[0], dp_q[N-1:1]};
    if (clrff)     dp_qm1 <= 1'b0;
    else if (enf)  dp_qm1 <= dp_q[0];
    if (ldc)       dp_cnt <= 3'(N);
    else if (dec)  dp_cnt <= dp_cnt - 3'd1;
    dp_q0_d  <= dp_q[0];
    dp_qm1_d <= dp_qm1;
  end

  assign q0       = dp_q0_d;
  assign qm1      = dp_qm1_d;
  assign eqz      = (dp_cnt == 3'd0);
  assign data_out = {dp_a[N-1:0], dp_q};

  // ---------------- reference model ----------------
  function automatic logic [W-1:0] ref_prod(input logic [N-1:0] m, input logic [N-1:0] q);
    int sm, sq;
    sm = int'(m);
    sq = int'(q);
    if (m[N-1]) sm = sm - (1 << N);
    if (q[N-1]) sq = sq - (1 << N);
    return W'(sm * sq);
  endfunction

  // Booth recoding adds or subtracts wherever adjacent multiplier bits differ.
  function automatic int booth_ops(input logic [N-1:0] q);
    int c;
    logic prev;
    c = 0;
    prev = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (q[i] != prev) c++;
      prev = q[i];
    end
    return c;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  logic [W-1:0] exp_q[$];
  int           lda_q[$];
  int           acc_q[$];
  int           done_cnt = 0;
  int           last_acc_cyc = 0;
  int           last_hs_cyc = 0;
  int           n_lda, n_dec, n_ldc, n_ovl, n_clrq;
  logic         prev_ov = 1'b0;
  logic         prev_or = 1'b0;
  logic [W-1:0] prev_prod = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      lda_q.delete();
      acc_q.delete();
      prev_ov = 1'b0;
      prev_or = 1'b0;
    end else begin
      if (in_valid && in_ready) begin
        exp_q.push_back(ref_prod(in_m, in_q));
        lda_q.push_back(booth_ops(in_q));
        acc_q.push_back(cyc);
        last_acc_cyc = cyc;
        n_lda = 0; n_dec = 0; n_ldc = 0; n_ovl = 0; n_clrq = 0;
      end
      if (lda) n_lda++;
      if (dec) n_dec++;
      if (ldc) n_ldc++;
      if (lda && sfta) n_ovl++;
      if (clrq) n_clrq++;
      assert (!(lda && sfta));

      if (out_valid && !prev_ov) begin
        if (acc_q.size() == 0) fail("out_valid_without_accept");
        else chk("latency", 64'(cyc - acc_q.pop_front()), 64'(3 * N + 3));
      end
      if (out_valid && prev_ov && !prev_or) begin
        chk("hold_product", product, prev_prod);
        chk("hold_in_ready", in_ready, 0);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          fail("unexpected_product");
        end else begin
          chk("product", product, exp_q.pop_front());
          chk("ldA_count", 64'(n_lda), 64'(lda_q.pop_front()));
          chk("dec_count", 64'(n_dec), 64'(N));
          chk("ldC_count", 64'(n_ldc), 1);
          chk("ldA_sftA_overlap", 64'(n_ovl), 0);
          chk("clrQ_count", 64'(n_clrq), 0);
        end
        last_hs_cyc = cyc;
        done_cnt++;
      end
      prev_ov   = out_valid;
      prev_or   = out_ready;
      prev_prod = product;
    end
  end

  // ---------------- driver tasks ----------------
  int rdy_mode = 0;  // 0: always ready, 1: random, 2: held low

  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       out_ready = 1'b1;
        1:       out_ready = 1'($urandom_range(0, 1));
        default: out_ready = 1'b0;
      endcase
    end
  end

  int done_target = 0;

  task automatic start_op(input logic [N-1:0] m, input logic [N-1:0] q);
    int t;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_m = m;
    in_q = q;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!in_ready && t < 200);
    if (!in_ready) fail("accept_timeout");
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_done(input int target);
    int t;
    t = 0;
    while (done_cnt < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt < target) fail("done_timeout");
  endtask

  task automatic run_op(input logic [N-1:0] m, input logic [N-1:0] q, input logic [W-1:0] expv);
    start_op(m, q);
    done_target++;
    wait_done(done_target);
    @(negedge clk);
    chk("product_directed", product, expv);
  endtask

  function automatic logic [11:0] strobes();
    return {lda, clra, sfta, ldq, clrq, sftq, ldm, clrff, add_sub, ldc, dec, enf};
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    int t;
    int evals;
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_m = '0;
    in_q = '0;
    repeat (2) @(negedge clk);
    chk("reset_in_ready", in_ready, 1);
    chk("reset_out_valid", out_valid, 0);
    chk("reset_product", product, 0);
    chk("reset_strobes", strobes(), 0);
    chk("reset_data_m", data_m, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // directed products
    rdy_mode = 0;
    run_op(4'h3, 4'h2, 8'h06);
    run_op(4'hD, 4'h2, 8'hFA);
    run_op(4'h7, 4'h8, 8'hC8);
    run_op(4'h8, 4'h8, 8'h40);
    run_op(4'h0, 4'h5, 8'h00);

    // back-pressure with a competing operand pair held on the input
    rdy_mode = 2;
    start_op(4'h5, 4'h3);
    done_target++;
    in_valid = 1'b1;
    in_m = 4'hE;
    in_q = 4'h5;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!out_valid && t < 100);
    if (!out_valid) fail("bp_out_valid_timeout");
    repeat (10) @(negedge clk);
    chk("bp_product", product, 8'h0F);
    chk("bp_no_accept", 64'(acc_q.size()), 0);
    chk("bp_data_m_held", data_m, 4'h5);
    rdy_mode = 0;
    @(negedge clk);
    rdy_mode = 2;
    @(negedge clk);
    chk("bp_in_ready_after", in_ready, 1);
    chk("bp_out_valid_after", out_valid, 0);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_accept_cycle", 64'(last_acc_cyc - last_hs_cyc), 1);
    chk("bp_data_m_new", data_m, 4'hE);
    rdy_mode = 0;
    done_target++;
    wait_done(done_target);
    @(negedge clk);
    chk("bp_second_product", product, 8'hF6);

    // asynchronous reset during the third EVAL
    start_op(4'h5, 4'h6);
    evals = 0;
    t = 0;
    while (evals < 3 && t < 100) begin
      @(negedge clk);
      t++;
      if (dbg_state == 3'd3) evals++;
    end
    if (evals < 3) fail("eval_not_reached");
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_product", product, 0);
    chk("midrst_strobes", strobes(), 0);
    chk("midrst_in_ready", in_ready, 1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    run_op(4'h2, 4'h3, 8'h06);

    // randomized operands under random back-pressure
    rdy_mode = 1;
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      start_op(N'($urandom_range(0, (1 << N) - 1)), N'($urandom_range(0, (1 << N) - 1)));
      done_target++;
    end
    wait_done(done_target);
    rdy_mode = 0;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(exp_q.size()), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog (t=%0t)", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
